// File: rtl/dram_read_checker.sv
`default_nettype none
// ============================================================================
// Module   : dram_read_checker
// Purpose  : Regenerates the address-derived write pattern and checks every
//            in-order read response, reporting pass/fail, errors, first bad address.
// Revision : 1.0 - initial release
// ============================================================================
module dram_read_checker #(
    parameter int ADDR_WIDTH  = 27,
    parameter int DATA_WIDTH  = 128,
    parameter int COUNT_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [COUNT_WIDTH-1:0] i_num_words,
    input  logic                   i_rdata_valid,
    input  logic [DATA_WIDTH-1:0]  i_rdata,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_pass,
    output logic [15:0]            o_err_count,
    output logic [ADDR_WIDTH-1:0]  o_first_err_addr,
    output logic                   o_stray
);

    localparam int c_LANES = DATA_WIDTH / 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_eaddr;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic [COUNT_WIDTH-1:0]  r_num_words;
    logic                    r_s1_valid;
    logic                    r_s1_mis;
    logic [ADDR_WIDTH-1:0]   r_s1_addr;
    logic [15:0]             r_err_count;
    logic [ADDR_WIDTH-1:0]   r_first_err_addr;
    logic                    r_stray;

    logic                    w_start;
    logic                    w_accept;
    logic                    w_last;
    logic [31:0]             w_addr32;
    logic [DATA_WIDTH-1:0]   w_pattern;

    assign w_start  = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_accept = i_rdata_valid && (r_state == ST_RUN);
    assign w_last   = (r_count == r_num_words - COUNT_WIDTH'(1));
    assign w_addr32 = 32'(r_eaddr);

    // Each 32-bit lane carries the word address plus its lane index.
    always_comb begin
        w_pattern = '0;
        for (int k = 0; k < c_LANES; k++) begin
            w_pattern[32*k +: 32] = w_addr32 + 32'(k);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_next = (i_num_words == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept && w_last) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: w_state_next = ST_DONE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state          <= ST_IDLE;
            r_eaddr          <= '0;
            r_count          <= '0;
            r_num_words      <= '0;
            r_s1_valid       <= 1'b0;
            r_s1_mis         <= 1'b0;
            r_s1_addr        <= '0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_stray          <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_s1_valid <= w_accept;
            r_s1_mis   <= (i_rdata != w_pattern);
            r_s1_addr  <= r_eaddr;

            if (w_start) begin
                r_eaddr          <= '0;
                r_count          <= '0;
                r_num_words      <= i_num_words;
                r_err_count      <= '0;
                r_first_err_addr <= '0;
                r_stray          <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_eaddr <= r_eaddr + ADDR_WIDTH'(8);
                    r_count <= r_count + COUNT_WIDTH'(1);
                end
                // A zero count means no mismatch yet, since the counter saturates.
                if (r_s1_valid && r_s1_mis) begin
                    if (r_err_count != 16'hFFFF) begin
                        r_err_count <= r_err_count + 16'd1;
                    end
                    if (r_err_count == 16'd0) begin
                        r_first_err_addr <= r_s1_addr;
                    end
                end
            end

            if (i_rdata_valid && r_state != ST_RUN) begin
                r_stray <= 1'b1;
            end
        end
    end

    assign o_busy           = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign o_done           = (r_state == ST_DONE);
    assign o_pass           = (r_state == ST_DONE) && (r_err_count == 16'd0);
    assign o_err_count      = r_err_count;
    assign o_first_err_addr = r_first_err_addr;
    assign o_stray          = r_stray;

endmodule
`default_nettype wire
